fetch_unit: RTL and testbench

//   Instruction fetch stage that drives the shared instruction/data memory's instruction port.
//   - Holds the PC and issues word addresses on instruction_memory_a.
//   - Gates instruction_memory_en and samples instruction_memory_v.
//   - Delivers each fetched word to decode over a valid/ready handshake.
//   - Handles branch redirects and stops fetching on the HALT_WORD sentinel.

---
 rtl/fetch_unit.sv | 210 +++++++++++++++++++++
 tb/tb_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage driving the shared memory's instruction port.
// Define FETCH_PERF_EN to add the Fetch_count / Flush_count performance counters.
module fetch_unit #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 65536,
    parameter int unsigned MEM_LAT   = 1,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Run,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_target,
    input  logic        Inst_ready,
    output logic        Inst_valid,
    output logic [31:0] Inst,
    output logic [31:0] Inst_pc,
    output logic        Halted,
`ifdef FETCH_PERF_EN
    output logic [31:0] Fetch_count,
    output logic [15:0] Flush_count,
`endif
    output logic        instruction_memory_en,
    output logic [31:0] instruction_memory_a,
    input  logic [31:0] instruction_memory_v
);
    localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);
    localparam logic [31:0] SENTINEL  = 32'hFFFF_FFFF;
    localparam int          CNT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    // ADDR lasts MEM_LAT cycles, so the counter runs MEM_LAT-1 down to 0.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [2:0] {IDLE, ARM, ADDR, HOLD, HALT, REARM} state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      inst_pc_q, inst_pc_d;
    logic             valid_q, valid_d;
    logic             halted_q, halted_d;

    logic [31:0] br_pc;
    logic [31:0] pc_inc;
    logic        branch_ok;
    logic        handshake;

    always_comb begin
        br_pc     = Branch_target & ~32'h3 & ADDR_MASK;
        pc_inc    = (pc_q + 32'd4) & ADDR_MASK;
        handshake = valid_q & Inst_ready;
        branch_ok = Branch_taken &&
                    (state_q == ARM || state_q == ADDR || state_q == HOLD || state_q == REARM);

        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        en_d      = en_q;
        a_d       = a_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        halted_d  = halted_q;

        if (branch_ok) begin
            pc_d    = br_pc;
            valid_d = 1'b0;
            cnt_d   = CNT_LOAD;
            if (state_q == REARM) begin
                en_d    = 1'b1;
                a_d     = SENTINEL;
                state_d = ARM;
            end else if (en_q && br_pc == a_q) begin
                // Same address would not trigger a read; drop en for a cycle to force one.
                en_d    = 1'b0;
                a_d     = SENTINEL;
                state_d = REARM;
            end else begin
                en_d    = 1'b1;
                a_d     = br_pc;
                state_d = ADDR;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Run) begin
                        en_d    = 1'b1;
                        state_d = ARM;
                    end
                end
                REARM: begin
                    if (!Run) begin
                        state_d = IDLE;
                    end else begin
                        en_d    = 1'b1;
                        state_d = ARM;
                    end
                end
                ARM: begin
                    if (!Run) begin
                        en_d    = 1'b0;
                        a_d     = SENTINEL;
                        state_d = IDLE;
                    end else begin
                        a_d     = pc_q;
                        cnt_d   = CNT_LOAD;
                        state_d = ADDR;
                    end
                end
                ADDR: begin
                    if (!Run) begin
                        en_d    = 1'b0;
                        a_d     = SENTINEL;
                        state_d = IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (instruction_memory_v == HALT_WORD) begin
                        halted_d = 1'b1;
                        en_d     = 1'b0;
                        a_d      = SENTINEL;
                        state_d  = HALT;
                    end else begin
                        inst_d    = instruction_memory_v;
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                        pc_d      = pc_inc;
                        state_d   = HOLD;
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        valid_d = 1'b0;
                        if (Run) begin
                            a_d     = pc_q;
                            cnt_d   = CNT_LOAD;
                            state_d = ADDR;
                        end else begin
                            en_d    = 1'b0;
                            a_d     = SENTINEL;
                            state_d = IDLE;
                        end
                    end
                end
                HALT: begin
                    en_d = 1'b0;
                    a_d  = SENTINEL;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            pc_q      <= PC_RESET;
            cnt_q     <= '0;
            en_q      <= 1'b0;
            a_q       <= SENTINEL;
            inst_q    <= '0;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            a_q       <= a_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            halted_q  <= halted_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        flush_count_d = flush_count_q;
        if (valid_q && Inst_ready && !Branch_taken) fetch_count_d = fetch_count_q + 32'd1;
        if (branch_ok && flush_count_q != 16'hFFFF) flush_count_d = flush_count_q + 16'd1;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign Fetch_count = fetch_count_q;
    assign Flush_count = flush_count_q;
`endif

    assign Inst_valid            = valid_q;
    assign Inst                  = inst_q;
    assign Inst_pc               = inst_pc_q;
    assign Halted                = halted_q;
    assign instruction_memory_en = en_q;
    assign instruction_memory_a  = a_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch scenarios plus a randomized run checked against a
// sequential-PC reference model (delivered pc/word stream, branches retarget the stream).
module tb_fetch_unit;
    localparam int unsigned MEM_BYTES = 65536;
    localparam logic [31:0] MASK      = 32'(MEM_BYTES - 1);
    localparam logic [31:0] HALTW     = 32'hFFFF_FFFF;
    localparam logic [31:0] SENT      = 32'hFFFF_FFFF;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Rst, Run, Branch_taken, Inst_ready;
    logic [31:0] Branch_target;
    logic        Inst_valid, Halted, mem_en;
    logic [31:0] Inst, Inst_pc, mem_a, mem_v;

    logic        run1, ready1;
    logic        valid1, halted1, en1;
    logic [31:0] inst1, pc1, a1, v1;
    logic        br1 = 1'b0;
    logic [31:0] tgt1 = 32'h0;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt, fetch_cnt1;
    logic [15:0] flush_cnt, flush_cnt1;
`endif

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] rd(input logic [31:0] a);
        logic [31:0] w;
        w = a & MASK & ~32'h3;
        if (mem.exists(w)) return mem[w];
        return {w[15:0] ^ 16'hA5A5, w[15:0]};
    endfunction

    // Single-cycle memory: data for the address driven at one rising edge is ready by the next.
    always @(negedge Clk) begin
        mem_v <= rd(mem_a);
        v1    <= rd(a1);
    end

    fetch_unit dut (
        .Clk(Clk), .Rst(Rst), .Run(Run), .Branch_taken(Branch_taken),
        .Branch_target(Branch_target), .Inst_ready(Inst_ready),
        .Inst_valid(Inst_valid), .Inst(Inst), .Inst_pc(Inst_pc), .Halted(Halted),
`ifdef FETCH_PERF_EN
        .Fetch_count(fetch_cnt), .Flush_count(flush_cnt),
`endif
        .instruction_memory_en(mem_en), .instruction_memory_a(mem_a),
        .instruction_memory_v(mem_v)
    );

    fetch_unit #(.PC_RESET(32'(MEM_BYTES - 4))) dut_wrap (
        .Clk(Clk), .Rst(Rst), .Run(run1), .Branch_taken(br1),
        .Branch_target(tgt1), .Inst_ready(ready1),
        .Inst_valid(valid1), .Inst(inst1), .Inst_pc(pc1), .Halted(halted1),
`ifdef FETCH_PERF_EN
        .Fetch_count(fetch_cnt1), .Flush_count(flush_cnt1),
`endif
        .instruction_memory_en(en1), .instruction_memory_a(a1),
        .instruction_memory_v(v1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Rst = 1'b1; Run = 1'b0; run1 = 1'b0; Branch_taken = 1'b0;
        Branch_target = '0; Inst_ready = 1'b0; ready1 = 1'b0;
        tick(); tick();
        Rst = 1'b0;
    endtask

    task automatic wait_valid(input int bound, output int cycles);
        cycles = 0;
        while (!Inst_valid && cycles < bound) begin
            tick();
            cycles++;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 32'(Inst_valid), 32'd0);
        chk({tag, "_inst"}, Inst, 32'd0);
        chk({tag, "_pc"}, Inst_pc, 32'd0);
        chk({tag, "_halted"}, 32'(Halted), 32'd0);
        chk({tag, "_en"}, 32'(mem_en), 32'd0);
        chk({tag, "_a"}, mem_a, SENT);
    endtask

    initial begin
        int          cyc, first, n;
        logic [31:0] got_pc [4];
        logic [31:0] got_in [4];
        logic [31:0] exp_pc, prev_inst, prev_pc, w;
        logic        started, prev_hold;
        int          idle, n_del, n_br;

        mem[32'h0] = 32'h1111_1111;
        mem[32'h4] = 32'h2222_2222;
        mem[32'h8] = HALTW;
        do_reset();
        chk_reset("rst");
        chk("rst_wrap_en", 32'(en1), 32'd0);
        chk("rst_wrap_a", a1, SENT);

        // Straight-line program ending in the halt sentinel.
        Run = 1'b1; Inst_ready = 1'b1;
        first = -1; n = 0;
        for (int c = 1; c <= 40 && !Halted; c++) begin
            tick();
            if (Inst_valid && first < 0) first = c;
            if (Inst_valid && Inst_ready && n < 4) begin
                got_pc[n] = Inst_pc; got_in[n] = Inst; n++;
            end
        end
        chk("t1_first_lat", 32'(first), 32'd3);
        chk("t1_count", 32'(n), 32'd2);
        chk("t1_pc0", got_pc[0], 32'h0);
        chk("t1_in0", got_in[0], 32'h1111_1111);
        chk("t1_pc1", got_pc[1], 32'h4);
        chk("t1_in1", got_in[1], 32'h2222_2222);
        chk("t1_halted", 32'(Halted), 32'd1);
        chk("t1_en", 32'(mem_en), 32'd0);
        chk("t1_valid", 32'(Inst_valid), 32'd0);
        tick(); tick();
        chk("t1_halt_sticky", 32'(Halted), 32'd1);

        // Decode stalls: held word stays put and no further fetch is issued.
        do_reset();
        Run = 1'b1; Inst_ready = 1'b0;
        wait_valid(10, cyc);
        chk("t2_valid", 32'(Inst_valid), 32'd1);
        chk("t2_a", mem_a, 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t2_hold_valid", 32'(Inst_valid), 32'd1);
            chk("t2_hold_inst", Inst, 32'h1111_1111);
            chk("t2_hold_pc", Inst_pc, 32'h0);
            chk("t2_hold_a", mem_a, 32'h0);
        end
        Inst_ready = 1'b1;
        tick();
        Inst_ready = 1'b0;
        wait_valid(10, cyc);
        chk("t2_next_pc", Inst_pc, 32'h4);
        chk("t2_next_inst", Inst, 32'h2222_2222);

        // Branch beats the handshake; low target bits are ignored.
        Branch_taken = 1'b1; Branch_target = 32'h103; Inst_ready = 1'b1;
        tick();
        Branch_taken = 1'b0; Inst_ready = 1'b0;
        chk("t3_flush", 32'(Inst_valid), 32'd0);
        chk("t3_a", mem_a, 32'h100);
        wait_valid(10, cyc);
        chk("t3_pc", Inst_pc, 32'h100);
        chk("t3_inst", Inst, rd(32'h100));
        chk("t3_not_halted", 32'(Halted), 32'd0);

        // Branch to the address already on the port forces a re-read via en low.
        Branch_taken = 1'b1; Branch_target = 32'h100;
        tick();
        Branch_taken = 1'b0;
        chk("t3s_en0", 32'(mem_en), 32'd0);
        chk("t3s_a_sent", mem_a, SENT);
        chk("t3s_valid", 32'(Inst_valid), 32'd0);
        tick();
        chk("t3s_en1", 32'(mem_en), 32'd1);
        chk("t3s_a_sent2", mem_a, SENT);
        tick();
        chk("t3s_a", mem_a, 32'h100);
        tick();
        chk("t3s_valid2", 32'(Inst_valid), 32'd1);
        chk("t3s_pc", Inst_pc, 32'h100);

        // Run drops while in ADDR: abort to IDLE and restart from the same pc.
        do_reset();
        Run = 1'b1;
        tick();
        chk("t5_arm_en", 32'(mem_en), 32'd1);
        chk("t5_arm_a", mem_a, SENT);
        tick();
        chk("t5_addr_a", mem_a, 32'h0);
        Run = 1'b0;
        tick();
        chk("t5_idle_valid", 32'(Inst_valid), 32'd0);
        chk("t5_idle_en", 32'(mem_en), 32'd0);
        chk("t5_idle_a", mem_a, SENT);
        tick();
        chk("t5_idle_valid2", 32'(Inst_valid), 32'd0);
        Run = 1'b1;
        wait_valid(10, cyc);
        chk("t5_restart_lat", 32'(cyc), 32'd3);
        chk("t5_restart_pc", Inst_pc, 32'h0);

        // Reset while an instruction is held.
        Inst_ready = 1'b1; Rst = 1'b1;
        tick();
        Rst = 1'b0; Run = 1'b0; Inst_ready = 1'b0;
        chk_reset("t6");
`ifdef FETCH_PERF_EN
        chk("t6_fetch_cnt", fetch_cnt, 32'd0);
        chk("t6_flush_cnt", 32'(flush_cnt), 32'd0);
`endif

        // PC wraps modulo MEM_BYTES.
        do_reset();
        run1 = 1'b1; ready1 = 1'b1; n = 0;
        for (int c = 0; c < 30 && n < 2; c++) begin
            tick();
            if (valid1 && ready1) begin
                got_pc[n] = pc1; got_in[n] = inst1; n++;
            end
        end
        chk("t4_count", 32'(n), 32'd2);
        chk("t4_pc0", got_pc[0], 32'h0000_FFFC);
        chk("t4_in0", got_in[0], rd(32'hFFFC));
        chk("t4_pc1", got_pc[1], 32'h0);
        chk("t4_in1", got_in[1], 32'h1111_1111);

        // Randomized run: random ready and branches against the pc-stream model.
        Rst = 1'b1;
        mem.delete();
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            if (w == HALTW) w = 32'h0;
            mem[32'(i * 4)] = w;
        end
        do_reset();
        Run = 1'b1;
        exp_pc = 32'h0; started = 1'b0; prev_hold = 1'b0;
        prev_inst = '0; prev_pc = '0; idle = 0; n_del = 0; n_br = 0;
        for (int c = 0; c < 600; c++) begin
            tick();
            if (prev_hold) begin
                chk("rnd_stall_valid", 32'(Inst_valid), 32'd1);
                chk("rnd_stall_inst", Inst, prev_inst);
                chk("rnd_stall_pc", Inst_pc, prev_pc);
            end
            if (Inst_valid) started = 1'b1;
            Inst_ready    = ($urandom_range(3) != 0);
            Branch_taken  = started && ($urandom_range(15) == 0);
            Branch_target = 32'($urandom_range(32'h3FF));
            if (Branch_taken) begin
                exp_pc = Branch_target & ~32'h3 & MASK;
                n_br++;
                idle++;
            end else if (Inst_valid && Inst_ready) begin
                chk("rnd_pc", Inst_pc, exp_pc);
                chk("rnd_inst", Inst, rd(exp_pc));
                exp_pc = (exp_pc + 32'd4) & MASK;
                n_del++;
                idle = 0;
            end else begin
                idle++;
            end
            if (idle > 60) begin
                chk("rnd_progress_timeout", 32'(idle), 32'd0);
                break;
            end
            prev_hold = Inst_valid && !Inst_ready && !Branch_taken;
            prev_inst = Inst;
            prev_pc   = Inst_pc;
        end
        Branch_taken = 1'b0;
        Inst_ready   = 1'b0;
        tick();
        chk("rnd_enough_deliveries", 32'(n_del > 50), 32'd1);
        chk("rnd_not_halted", 32'(Halted), 32'd0);
`ifdef FETCH_PERF_EN
        chk("rnd_fetch_cnt", fetch_cnt, 32'(n_del));
        chk("rnd_flush_cnt", 32'(flush_cnt), 32'(n_br));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end
endmodule
